// File: rtl/rt_keystream_stage_pkg.sv
// Shared definitions for the keystream stage slice.
//   BLK_W / STATE_WORDS / STATE_W : block, word-count and state widths
//   ks_state_e                    : stage FSM encoding
//   word_sel()                    : returns word Wi (MSB-first) of a 768-bit state
package rt_keystream_stage_pkg;

   localparam int BLK_W       = 128;
   localparam int STATE_WORDS = 6;
   localparam int STATE_W     = BLK_W * STATE_WORDS;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_WAIT_MSG = 2'd1,
      ST_OUT      = 2'd2,
      ST_TAG      = 2'd3
   } ks_state_e;

   // W0 occupies bits [0:127]; shifting toward index 0 brings Wi to the top word.
   function automatic logic [0:BLK_W-1] word_sel(input logic [0:STATE_W-1] st,
                                                  input int unsigned      idx);
      logic [0:STATE_W-1] sh;
      sh = st << (BLK_W * idx);
      return sh[0:BLK_W-1];
   endfunction

endpackage

// File: rtl/rt_ks_func.sv
// Combinational keystream / tag fold of a 768-bit round state.
//   st   : state W0..W5, MSB-first
//   ks   : W1 ^ W4 ^ W5 ^ (W2 & W3)
//   fold : W0 ^ W1 ^ W2 ^ W3 ^ W4 ^ W5
module rt_ks_func
   import rt_keystream_stage_pkg::*;
(
   input  logic [0:STATE_W-1] st,
   output logic [0:BLK_W-1]   ks,
   output logic [0:BLK_W-1]   fold
);

   always_comb begin
      ks = word_sel(st, 1) ^ word_sel(st, 4) ^ word_sel(st, 5)
         ^ (word_sel(st, 2) & word_sel(st, 3));
      fold = '0;
      for (int unsigned i = 0; i < STATE_WORDS; i++) begin
         fold = fold ^ word_sel(st, i);
      end
   end

endmodule

// File: rtl/rt_keystream_stage.sv
// Keystream stage: captures a round state, XORs its keystream with the paired
// message block, returns the result over valid/ready and, on the last block,
// emits a 128-bit fold tag.
//   clk, rst             : clock, synchronous active-high reset
//   st_in/st_valid/st_ready       : state input handshake
//   msg_in/msg_last/msg_valid/msg_ready : message input handshake
//   dec                  : direction label, sampled with the state
//   out_blk/out_valid/out_ready   : result output handshake
//   tag/tag_valid        : tag and its one-cycle strobe
//   blk_cnt              : output blocks accepted since reset (wraps)
// Optional: define RT_KS_ZEROIZE_EN to clear the state register and out_blk
// on the cycle after tag_valid.
module rt_keystream_stage
   import rt_keystream_stage_pkg::*;
#(
   parameter int CNT_W = 32,
   parameter int TAG_W = 128
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [0:767]       st_in,
   input  logic               st_valid,
   output logic               st_ready,
   input  logic [0:127]       msg_in,
   input  logic               msg_last,
   input  logic               msg_valid,
   output logic               msg_ready,
   input  logic               dec,
   output logic [0:127]       out_blk,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [0:127]       tag,
   output logic               tag_valid,
   output logic [CNT_W-1:0]   blk_cnt
);

   // Keeps the first TAG_W bits (MSB-first) of the fold.
   localparam logic [0:BLK_W-1] TAG_MASK = ~({BLK_W{1'b1}} >> TAG_W);

   ks_state_e          state_q, state_d;
   logic [0:STATE_W-1] st_q;
   logic               dec_q;
   logic               last_q;
   logic [0:BLK_W-1]   out_q;
   logic [0:BLK_W-1]   tag_q;
   logic [CNT_W-1:0]   cnt_q;
   logic [0:BLK_W-1]   ks;
   logic [0:BLK_W-1]   fold;

   rt_ks_func u_ks_func (
      .st   (st_q),
      .ks   (ks),
      .fold (fold)
   );

   // dec_q is the direction label for the upstream M2 mux; it has no
   // consumer inside this block.
   logic unused_dec;
   assign unused_dec = dec_q;

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:     if (st_valid)  state_d = ST_WAIT_MSG;
         ST_WAIT_MSG: if (msg_valid) state_d = ST_OUT;
         ST_OUT:      if (out_ready) state_d = last_q ? ST_TAG : ST_IDLE;
         ST_TAG:                     state_d = ST_IDLE;
         default:                    state_d = ST_IDLE;
      endcase
   end

   // Readies depend only on the FSM state; rst masks them so nothing is
   // advertised while reset is held.
   assign st_ready  = !rst && (state_q == ST_IDLE);
   assign msg_ready = !rst && (state_q == ST_WAIT_MSG);
   assign out_valid = (state_q == ST_OUT);
   assign tag_valid = (state_q == ST_TAG);
   assign out_blk   = out_q;
   assign tag       = tag_q;
   assign blk_cnt   = cnt_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         st_q    <= '0;
         dec_q   <= 1'b0;
         last_q  <= 1'b0;
         out_q   <= '0;
         tag_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         if (state_q == ST_IDLE && st_valid) begin
            st_q  <= st_in;
            dec_q <= dec;
         end
         if (state_q == ST_WAIT_MSG && msg_valid) begin
            out_q  <= msg_in ^ ks;
            last_q <= msg_last;
         end
         if (state_q == ST_OUT && out_ready) begin
            cnt_q <= cnt_q + CNT_W'(1);
            // Tag is registered on entry to TAG so it is valid with the pulse.
            if (last_q) tag_q <= fold & TAG_MASK;
         end
`ifdef RT_KS_ZEROIZE_EN
         if (state_q == ST_TAG) begin
            st_q  <= '0;
            out_q <= '0;
         end
`endif
      end
   end

endmodule

// File: tb/tb_rt_keystream_stage.sv
// Self-checking bench for rt_keystream_stage (built with CNT_W = 4 so the
// counter wrap is reachable). Directed table, hand-written corner sequences
// and randomized blocks checked against a word-level reference model.
module tb_rt_keystream_stage;

   localparam int CNT_W = 4;

   logic               clk = 1'b0;
   logic               rst;
   logic [767:0]       st_in;
   logic               st_valid;
   logic               st_ready;
   logic [127:0]       msg_in;
   logic               msg_last;
   logic               msg_valid;
   logic               msg_ready;
   logic               dec;
   logic [127:0]       out_blk;
   logic               out_valid;
   logic               out_ready;
   logic [127:0]       tag;
   logic               tag_valid;
   logic [CNT_W-1:0]   blk_cnt;

   int checks = 0;
   int errors = 0;
   int exp_cnt = 0;

   rt_keystream_stage #(.CNT_W(CNT_W), .TAG_W(128)) dut (
      .clk       (clk),
      .rst       (rst),
      .st_in     (st_in),
      .st_valid  (st_valid),
      .st_ready  (st_ready),
      .msg_in    (msg_in),
      .msg_last  (msg_last),
      .msg_valid (msg_valid),
      .msg_ready (msg_ready),
      .dec       (dec),
      .out_blk   (out_blk),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .tag       (tag),
      .tag_valid (tag_valid),
      .blk_cnt   (blk_cnt)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic [767:0] st;
      logic [127:0] msg;
      bit           last;
      int           hold;
      logic [127:0] exp_out;
      logic [127:0] exp_tag;
   } vec_t;

   // Reference model: word i counted from the most significant end.
   function automatic logic [127:0] w(input logic [767:0] s, input int i);
      return 128'(s >> (128 * (5 - i)));
   endfunction

   function automatic logic [127:0] model_ks(input logic [767:0] s);
      return w(s, 1) ^ w(s, 4) ^ w(s, 5) ^ (w(s, 2) & w(s, 3));
   endfunction

   function automatic logic [127:0] model_tag(input logic [767:0] s);
      logic [127:0] t = '0;
      for (int i = 0; i < 6; i++) t = t ^ w(s, i);
      return t;
   endfunction

   task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   // One full transaction; all driving and sampling happens on negedges.
   task automatic run_block(input logic [767:0] s, input logic [127:0] m, input bit last,
                            input bit d, input int hold,
                            input logic [127:0] exp_out, input logic [127:0] exp_tag);
      int n;
      st_in = s; st_valid = 1'b1; dec = d;
      n = 0;
      while (!st_ready) begin
         if (n++ > 50) begin
            check("st_ready_timeout", 0, 1);
            st_valid = 1'b0;
            return;
         end
         @(negedge clk);
      end
      @(negedge clk);
      st_valid = 1'b0;
      check("st_ready_busy", st_ready, 0);
      check("msg_ready", msg_ready, 1);
      msg_in = m; msg_last = last; msg_valid = 1'b1;
      @(negedge clk);
      msg_valid = 1'b0;
      check("out_valid", out_valid, 1);
      check("out_blk", out_blk, exp_out);
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         check("hold_out_valid", out_valid, 1);
         check("hold_out_blk", out_blk, exp_out);
         check("hold_st_ready", st_ready, 0);
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      exp_cnt = (exp_cnt + 1) % (1 << CNT_W);
      check("blk_cnt", 128'(blk_cnt), 128'(exp_cnt));
      check("out_valid_drop", out_valid, 0);
      if (last) begin
         check("tag_valid", tag_valid, 1);
         check("tag", tag, exp_tag);
         @(negedge clk);
         check("tag_pulse_end", tag_valid, 0);
         check("tag_hold", tag, exp_tag);
      end else begin
         check("tag_valid_low", tag_valid, 0);
      end
      check("idle_st_ready", st_ready, 1);
   endtask

   vec_t vecs[4];

   initial begin
      logic [767:0] s;
      logic [127:0] m;
      bit           last;
      logic [127:0] w1c;

      w1c = 128'h0123456789ABCDEF0123456789ABCDEF;
      vecs[0] = '{st: {128'h0, 128'h0, {128{1'b1}}, {128{1'b1}}, 128'h0, 128'h0},
                  msg: 128'h0, last: 1'b0, hold: 0,
                  exp_out: {128{1'b1}}, exp_tag: 128'h0};
      vecs[1] = '{st: {128'h0, w1c, 128'h0, 128'h0, 128'h0, 128'h0},
                  msg: {128{1'b1}}, last: 1'b0, hold: 0,
                  exp_out: 128'hFEDCBA9876543210FEDCBA9876543210, exp_tag: 128'h0};
      vecs[2] = '{st: {128'h0, w1c, 128'h0, 128'h0, 128'h0, 128'h0},
                  msg: 128'h5A, last: 1'b0, hold: 5,
                  exp_out: w1c ^ 128'h5A, exp_tag: 128'h0};
      vecs[3] = '{st: {128'd1, 128'd2, 128'd4, 128'd8, 128'd16, 128'd32},
                  msg: 128'h0, last: 1'b1, hold: 1,
                  exp_out: 128'h32, exp_tag: 128'h3F};

      rst = 1'b1; st_in = '0; st_valid = 1'b0; msg_in = '0; msg_last = 1'b0;
      msg_valid = 1'b0; dec = 1'b0; out_ready = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_st_ready", st_ready, 0);
      check("rst_msg_ready", msg_ready, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_out_blk", out_blk, 0);
      check("rst_tag_valid", tag_valid, 0);
      check("rst_tag", tag, 0);
      check("rst_blk_cnt", 128'(blk_cnt), 0);
      rst = 1'b0;
      #1 check("rel_st_ready", st_ready, 1);
      @(negedge clk);

      foreach (vecs[i])
         run_block(vecs[i].st, vecs[i].msg, vecs[i].last, i[0], vecs[i].hold,
                   vecs[i].exp_out, vecs[i].exp_tag);

      // State and message offered together in IDLE: only the state is taken.
      s = vecs[1].st; m = 128'hC3;
      st_in = s; st_valid = 1'b1; msg_in = m; msg_last = 1'b0; msg_valid = 1'b1;
      @(negedge clk);
      st_valid = 1'b0;
      check("simul_out_valid", out_valid, 0);
      check("simul_msg_ready", msg_ready, 1);
      @(negedge clk);
      msg_valid = 1'b0;
      check("simul_out_blk", out_blk, m ^ model_ks(s));
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      exp_cnt = (exp_cnt + 1) % (1 << CNT_W);
      check("simul_blk_cnt", 128'(blk_cnt), 128'(exp_cnt));

      // Reset while a result is waiting in OUT.
      st_in = vecs[0].st; st_valid = 1'b1;
      @(negedge clk);
      st_valid = 1'b0; msg_in = 128'h1; msg_valid = 1'b1;
      @(negedge clk);
      msg_valid = 1'b0;
      check("pre_rst_out_valid", out_valid, 1);
      rst = 1'b1;
      @(negedge clk);
      check("midrst_out_valid", out_valid, 0);
      check("midrst_out_blk", out_blk, 0);
      check("midrst_blk_cnt", 128'(blk_cnt), 0);
      check("midrst_tag", tag, 0);
      check("midrst_st_ready", st_ready, 0);
      rst = 1'b0;
      exp_cnt = 0;
      #1 check("postrst_st_ready", st_ready, 1);
      @(negedge clk);

      // Randomized blocks; 17 from a cleared counter exercises the wrap.
      for (int k = 0; k < 17; k++) begin
         for (int j = 0; j < 24; j++) s = {s[735:0], 32'($urandom)};
         m = {32'($urandom), 32'($urandom), 32'($urandom), 32'($urandom)};
         last = ($urandom_range(0, 3) == 0);
         run_block(s, m, last, 1'($urandom), $urandom_range(0, 3),
                   m ^ model_ks(s), model_tag(s));
      end
      check("wrap_blk_cnt", 128'(blk_cnt), 128'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
